// File: rtl/oled_ctrl.sv
// SSD1306 128x32 OLED sequencer: power-up order, init commands, SPI shifter and frame streamer.
// Defining OLED_SHUTDOWN_EN adds the shutdown_i power-down sequence ending in a halt state.
module oled_ctrl #(
  parameter int unsigned SCK_DIV        = 4,
  parameter int unsigned VDD_DELAY_CYC  = 100000,
  parameter int unsigned RES_PULSE_CYC  = 300,
  parameter int unsigned VBAT_DELAY_CYC = 10000000,
  parameter int unsigned FRAME_BYTES    = 512
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_req_i,
`ifdef OLED_SHUTDOWN_EN
  input  logic       shutdown_i,
`endif
  output logic [8:0] pix_addr_o,
  input  logic [7:0] pix_data_i,
  output logic       ready_o,
  output logic       mosi_o,
  output logic       sck_o,
  output logic       cs_o,
  output logic       dc_o,
  output logic       vbat_o,
  output logic       vdd_o,
  output logic       res_o
);

  localparam int unsigned MaxA     = (VDD_DELAY_CYC > RES_PULSE_CYC) ? VDD_DELAY_CYC
                                                                      : RES_PULSE_CYC;
  localparam int unsigned MaxDelay = (MaxA > VBAT_DELAY_CYC) ? MaxA : VBAT_DELAY_CYC;
  localparam int unsigned CntW     = $clog2(MaxDelay + 1);
  localparam int unsigned DivW     = $clog2(2 * SCK_DIV + 1);
  localparam int unsigned MaxBurst = (FRAME_BYTES > 9) ? FRAME_BYTES : 9;
  localparam int unsigned IdxW     = $clog2(MaxBurst + 1);

  typedef enum logic [3:0] {
    StOff, StVddWait, StSendAe, StResLo, StResHi, StInit1, StVbatWait, StInit2,
    StIdle, StFrCmd, StFrData, StSdAe, StSdVbat, StHalt
  } state_e;

  typedef enum logic [1:0] {PhSetup, PhShift, PhTail, PhGap} phase_e;

  state_e          state_q;
  phase_e          phase_q;
  logic [CntW-1:0] cnt_q;
  logic [DivW-1:0] div_q;
  logic [3:0]      bit_q;
  logic [IdxW-1:0] idx_q;
  logic [6:0]      sh_q;
  logic [8:0]      pix_addr_q;
  logic            cs_q, sck_q, mosi_q, dc_q, vdd_q, vbat_q, res_q, ready_q, pend_q;
`ifdef OLED_SHUTDOWN_EN
  logic            sd_pend_q;
`endif

  // Command bytes: AE | 8D 14 D9 F1 | 81 0F A1 C8 DA 20 20 00 AF | 21 00 7F 22 00 03
  function automatic logic [7:0] cmd_rom(input logic [4:0] a);
    case (a)
      5'd0:  cmd_rom = 8'hAE;
      5'd1:  cmd_rom = 8'h8D;
      5'd2:  cmd_rom = 8'h14;
      5'd3:  cmd_rom = 8'hD9;
      5'd4:  cmd_rom = 8'hF1;
      5'd5:  cmd_rom = 8'h81;
      5'd6:  cmd_rom = 8'h0F;
      5'd7:  cmd_rom = 8'hA1;
      5'd8:  cmd_rom = 8'hC8;
      5'd9:  cmd_rom = 8'hDA;
      5'd10: cmd_rom = 8'h20;
      5'd11: cmd_rom = 8'h20;
      5'd12: cmd_rom = 8'h00;
      5'd13: cmd_rom = 8'hAF;
      5'd14: cmd_rom = 8'h21;
      5'd15: cmd_rom = 8'h00;
      5'd16: cmd_rom = 8'h7F;
      5'd17: cmd_rom = 8'h22;
      5'd18: cmd_rom = 8'h00;
      5'd19: cmd_rom = 8'h03;
      default: cmd_rom = 8'h00;
    endcase
  endfunction

  logic            in_burst, in_wait, wait_done, div_end, gap_end, last_byte, burst_done;
  logic [4:0]      rom_base;
  logic [IdxW-1:0] last_idx, ld_idx;
  logic [CntW-1:0] wait_last;
  logic [7:0]      cur_byte;
  logic [8:0]      pix_next;

  always_comb begin
    in_burst  = 1'b0;
    in_wait   = 1'b0;
    rom_base  = 5'd0;
    last_idx  = '0;
    wait_last = '0;
    case (state_q)
      StSendAe, StSdAe: in_burst = 1'b1;
      StInit1:  begin in_burst = 1'b1; rom_base = 5'd1;  last_idx = IdxW'(3); end
      StInit2:  begin in_burst = 1'b1; rom_base = 5'd5;  last_idx = IdxW'(8); end
      StFrCmd:  begin in_burst = 1'b1; rom_base = 5'd14; last_idx = IdxW'(5); end
      StFrData: begin in_burst = 1'b1; last_idx = IdxW'(FRAME_BYTES - 1); end
      StVddWait: begin in_wait = 1'b1; wait_last = CntW'(VDD_DELAY_CYC - 1); end
      StResLo, StResHi: begin in_wait = 1'b1; wait_last = CntW'(RES_PULSE_CYC - 1); end
      StVbatWait, StSdVbat: begin in_wait = 1'b1; wait_last = CntW'(VBAT_DELAY_CYC - 1); end
      default: ;
    endcase
    wait_done  = (cnt_q == wait_last);
    div_end    = (div_q == DivW'(SCK_DIV - 1));
    gap_end    = (div_q == DivW'(2 * SCK_DIV - 1));
    last_byte  = (idx_q == last_idx);
    burst_done = in_burst && (phase_q == PhGap) && gap_end;
    // Index of the byte about to be loaded into the shifter.
    ld_idx     = (phase_q == PhSetup) ? idx_q : idx_q + 1'b1;
    cur_byte   = (state_q == StFrData) ? pix_data_i : cmd_rom(rom_base + 5'(ld_idx));
    // Prefetch: address of the following byte is issued a whole byte-time before it is loaded.
    pix_next   = ((state_q == StFrData) && (ld_idx != IdxW'(FRAME_BYTES - 1)))
                 ? 9'(ld_idx + 1'b1) : 9'd0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StOff;
      phase_q    <= PhSetup;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      sh_q       <= '0;
      pix_addr_q <= '0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      dc_q       <= 1'b0;
      vdd_q      <= 1'b1;
      vbat_q     <= 1'b1;
      res_q      <= 1'b1;
      ready_q    <= 1'b0;
      pend_q     <= 1'b0;
`ifdef OLED_SHUTDOWN_EN
      sd_pend_q  <= 1'b0;
`endif
    end else begin
      if (frame_req_i && state_q != StIdle) pend_q <= 1'b1;
`ifdef OLED_SHUTDOWN_EN
      if (shutdown_i && state_q != StIdle) sd_pend_q <= 1'b1;
`endif
      if (in_wait) cnt_q <= wait_done ? '0 : cnt_q + 1'b1;

      if (in_burst) begin
        case (phase_q)
          PhSetup: begin
            cs_q <= 1'b0;
            if (div_end) begin
              div_q      <= '0;
              phase_q    <= PhShift;
              bit_q      <= '0;
              sh_q       <= cur_byte[6:0];
              mosi_q     <= cur_byte[7];
              idx_q      <= ld_idx;
              pix_addr_q <= pix_next;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          PhShift: begin
            if (div_end) begin
              div_q <= '0;
              if (bit_q == 4'd15) begin
                sck_q <= 1'b0;
                if (last_byte) begin
                  phase_q <= PhTail;
                end else begin
                  bit_q      <= '0;
                  sh_q       <= cur_byte[6:0];
                  mosi_q     <= cur_byte[7];
                  idx_q      <= ld_idx;
                  pix_addr_q <= pix_next;
                end
              end else begin
                bit_q <= bit_q + 1'b1;
                sck_q <= ~bit_q[0];
                if (bit_q[0]) begin
                  mosi_q <= sh_q[6];
                  sh_q   <= {sh_q[5:0], 1'b0};
                end
              end
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          PhTail: begin
            if (div_end) begin
              cs_q    <= 1'b1;
              div_q   <= '0;
              phase_q <= PhGap;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
          default: begin
            if (gap_end) begin
              div_q   <= '0;
              idx_q   <= '0;
              phase_q <= PhSetup;
            end else begin
              div_q <= div_q + 1'b1;
            end
          end
        endcase
      end

      case (state_q)
        StOff:      begin vdd_q <= 1'b0; state_q <= StVddWait; end
        StVddWait:  if (wait_done) begin dc_q <= 1'b0; state_q <= StSendAe; end
        StSendAe:   if (burst_done) begin res_q <= 1'b0; state_q <= StResLo; end
        StResLo:    if (wait_done) begin res_q <= 1'b1; state_q <= StResHi; end
        StResHi:    if (wait_done) begin dc_q <= 1'b0; state_q <= StInit1; end
        StInit1:    if (burst_done) begin vbat_q <= 1'b0; state_q <= StVbatWait; end
        StVbatWait: if (wait_done) state_q <= StInit2;
        StInit2:    if (burst_done) begin ready_q <= 1'b1; state_q <= StIdle; end
        StIdle: begin
`ifdef OLED_SHUTDOWN_EN
          // Shutdown wins and drops any frame still owed.
          if (shutdown_i || sd_pend_q) begin
            ready_q   <= 1'b0;
            pend_q    <= 1'b0;
            sd_pend_q <= 1'b0;
            dc_q      <= 1'b0;
            state_q   <= StSdAe;
          end else
`endif
          if (frame_req_i || pend_q) begin
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            dc_q    <= 1'b0;
            state_q <= StFrCmd;
          end
        end
        StFrCmd:    if (burst_done) begin dc_q <= 1'b1; state_q <= StFrData; end
        StFrData:   if (burst_done) begin ready_q <= 1'b1; state_q <= StIdle; end
`ifdef OLED_SHUTDOWN_EN
        StSdAe:     if (burst_done) begin vbat_q <= 1'b1; state_q <= StSdVbat; end
        StSdVbat:   if (wait_done) begin vdd_q <= 1'b1; state_q <= StHalt; end
        StHalt:     ;
`endif
        default:    state_q <= StOff;
      endcase
    end
  end

  assign pix_addr_o = pix_addr_q;
  assign ready_o    = ready_q;
  assign mosi_o     = mosi_q;
  assign sck_o      = sck_q;
  assign cs_o       = cs_q;
  assign dc_o       = dc_q;
  assign vbat_o     = vbat_q;
  assign vdd_o      = vdd_q;
  assign res_o      = res_q;

endmodule

// File: tb/tb_oled_ctrl.sv
// Bench for oled_ctrl: SPI monitor decodes bytes against a scoreboard of expected {dc, byte}.
module tb_oled_ctrl;

  localparam int unsigned SckDiv   = 2;
  localparam int unsigned VbatCyc  = 40;
  localparam int unsigned FrBytes  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_req = 1'b0;
  logic [8:0] pix_addr;
  logic [7:0] pix_data = 8'h00;
  logic       ready, mosi, sck, cs, dc, vbat, vdd, res;
`ifdef OLED_SHUTDOWN_EN
  logic       shutdown = 1'b0;
`endif

  oled_ctrl #(
    .SCK_DIV(SckDiv), .VDD_DELAY_CYC(20), .RES_PULSE_CYC(8),
    .VBAT_DELAY_CYC(VbatCyc), .FRAME_BYTES(FrBytes)
  ) dut (
    .clk_i(clk), .rst_i(rst), .frame_req_i(frame_req),
`ifdef OLED_SHUTDOWN_EN
    .shutdown_i(shutdown),
`endif
    .pix_addr_o(pix_addr), .pix_data_i(pix_data), .ready_o(ready), .mosi_o(mosi),
    .sck_o(sck), .cs_o(cs), .dc_o(dc), .vbat_o(vbat), .vdd_o(vdd), .res_o(res)
  );

  always #5 clk = ~clk;

  // Framebuffer with synchronous read.
  always @(posedge clk) pix_data <= pix_addr[7:0] ^ 8'h5A;

  logic [8:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int n_popped = 0;

  // SPI monitor, sampling away from the active edge.
  logic       cs_p = 1'b1, sck_p = 1'b0, mosi_p = 1'b0;
  logic       first_rise = 1'b0, had_burst = 1'b0, bus_bad = 1'b0, burst_dc = 1'b0;
  logic [7:0] shreg = 8'h00;
  logic [8:0] exp_b;
  int lo_cyc = 0, hi_cyc = 0, nbits = 0;

  always @(negedge clk) begin
    if (rst) begin
      cs_p = 1'b1; sck_p = 1'b0; mosi_p = 1'b0;
      nbits = 0; had_burst = 1'b0; bus_bad = 1'b0; hi_cyc = 0; lo_cyc = 0;
    end else begin
      if (cs && sck) bus_bad = 1'b1;
      if (cs_p && !cs) begin
        n_tests++;
        if (had_burst && hi_cyc + 1 < 2 * SckDiv) begin
          n_fail++;
          $display("FAIL cs_gap: cs high %0d cycles, required >= %0d", hi_cyc + 1, 2 * SckDiv);
        end
        lo_cyc = 0; first_rise = 1'b1; burst_dc = dc; nbits = 0;
      end else if (!cs) begin
        lo_cyc++;
      end
      if (!cs_p && cs) begin
        hi_cyc = 0; had_burst = 1'b1;
      end else if (cs) begin
        hi_cyc++;
      end
      if (!cs && dc !== burst_dc) bus_bad = 1'b1;
      if (!cs && sck && !sck_p) begin
        if (first_rise && lo_cyc < SckDiv) bus_bad = 1'b1;
        first_rise = 1'b0;
        if (mosi !== mosi_p) bus_bad = 1'b1;
        shreg = {shreg[6:0], mosi};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL spi_byte: got dc=%0b byte=%h, required no byte", burst_dc, shreg);
          end else begin
            exp_b = exp_q.pop_front();
            n_popped++;
            if ({burst_dc, shreg} !== exp_b) begin
              n_fail++;
              $display("FAIL spi_byte: got dc=%0b byte=%h, required dc=%0b byte=%h",
                       burst_dc, shreg, exp_b[8], exp_b[7:0]);
            end
          end
          n_tests++;
          if (bus_bad) begin
            n_fail++;
            $display("FAIL bus_timing: byte %h had setup/stability violation, required none",
                     shreg);
          end
          bus_bad = 1'b0;
        end
      end
      cs_p = cs; sck_p = sck; mosi_p = mosi;
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic push_init();
    logic [7:0] b [14];
    b = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'h0F, 8'hA1, 8'hC8, 8'hDA,
          8'h20, 8'h20, 8'h00, 8'hAF};
    for (int i = 0; i < 14; i++) exp_q.push_back({1'b0, b[i]});
  endtask

  task automatic push_frame();
    logic [7:0] b [6];
    b = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h03};
    for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, b[i]});
    for (int k = 0; k < int'(FrBytes); k++) exp_q.push_back({1'b1, 8'(k) ^ 8'h5A});
  endtask

  task automatic pulse_frame_req();
    @(negedge clk) frame_req = 1'b1;
    @(negedge clk) frame_req = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    n_tests++;
    if ({cs, sck, mosi, dc, vdd, vbat, res, ready} !== 8'b1000_1110) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b, required 10001110", {cs, sck, mosi, dc, vdd, vbat, res, ready});
    end
    n_tests++;
    if (pix_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_pix_addr: got %0d, required 0", pix_addr);
    end
  endtask

  task automatic test_power_up();
    int base, w, i;
    push_init();
    base = n_popped;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({vdd, vbat, res} !== 3'b011) begin
      n_fail++;
      $display("FAIL vdd_first_clk: got vdd/vbat/res=%b, required 011", {vdd, vbat, res});
    end
    for (i = 0; i < 500 && res; i++) @(negedge clk);
    n_tests++;
    if (res || n_popped - base != 1) begin
      n_fail++;
      $display("FAIL res_low_after_ae: got res=%0b bytes=%0d, required res=0 bytes=1", res, n_popped - base);
    end
    w = 0;
    while (!res && w < 100) begin @(negedge clk); w++; end
    n_tests++;
    if (w != 8) begin
      n_fail++;
      $display("FAIL res_width: got %0d cycles, required 8", w);
    end
    for (i = 0; i < 2000 && vbat; i++) @(negedge clk);
    n_tests++;
    if (vbat || n_popped - base != 5) begin
      n_fail++;
      $display("FAIL vbat_on: got vbat=%0b bytes=%0d, required vbat=0 bytes=5", vbat, n_popped - base);
    end
    w = 0;
    while (cs && w < 1000) begin @(negedge clk); w++; end
    n_tests++;
    if (w < int'(VbatCyc)) begin
      n_fail++;
      $display("FAIL vbat_delay: got %0d cycles before 81, required >= %0d", w, VbatCyc);
    end
    for (i = 0; i < 3000 && !ready; i++) @(negedge clk);
    n_tests++;
    if (!ready || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL init_done: got ready=%0b left=%0d, required ready=1 left=0", ready, exp_q.size());
    end
  endtask

  task automatic test_frame();
    int base, i;
    base = n_popped;
    push_frame();
    pulse_frame_req();
    n_tests++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_ready_low: got %0b, required 0", ready);
    end
    for (i = 0; i < 2000 && !ready; i++) @(negedge clk);
    n_tests++;
    if (!ready || n_popped - base != 14) begin
      n_fail++;
      $display("FAIL frame_done: got ready=%0b bytes=%0d, required ready=1 bytes=14", ready, n_popped - base);
    end
    n_tests++;
    if (pix_addr !== 9'd0) begin
      n_fail++;
      $display("FAIL frame_pix_addr: got %0d, required 0", pix_addr);
    end
  endtask

  task automatic test_pending();
    int base, i;
    base = n_popped;
    push_frame();
    pulse_frame_req();
    cycles(60);
    for (int j = 0; j < 3; j++) begin pulse_frame_req(); cycles(5); end
    push_frame();
    for (i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    for (i = 0; i < 500 && !ready; i++) @(negedge clk);
    cycles(300);
    n_tests++;
    if (!ready || !cs || n_popped - base != 28) begin
      n_fail++;
      $display("FAIL pending_frames: got ready=%0b cs=%0b bytes=%0d, required 1 1 28", ready, cs, n_popped - base);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base, i;
    base = n_popped;
    push_frame();
    pulse_frame_req();
    for (i = 0; i < 3000 && n_popped - base < 9; i++) @(negedge clk);
    cycles(6);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({cs, vdd, vbat, ready, sck} !== 5'b11100) begin
      n_fail++;
      $display("FAIL async_reset: got cs/vdd/vbat/ready/sck=%b, required 11100", {cs, vdd, vbat, ready, sck});
    end
    exp_q.delete();
    cycles(10);
    test_power_up();
    test_frame();
  endtask

`ifdef OLED_SHUTDOWN_EN
  task automatic test_shutdown();
    int i, w;
    logic cs_seen;
    exp_q.push_back({1'b0, 8'hAE});
    @(negedge clk) shutdown = 1'b1;
    @(negedge clk) shutdown = 1'b0;
    for (i = 0; i < 500 && !vbat; i++) @(negedge clk);
    n_tests++;
    if (!vbat || vdd || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sd_vbat: got vbat=%0b vdd=%0b left=%0d, required 1 0 0", vbat, vdd, exp_q.size());
    end
    w = 0;
    while (!vdd && w < 200) begin @(negedge clk); w++; end
    n_tests++;
    if (w != int'(VbatCyc)) begin
      n_fail++;
      $display("FAIL sd_vdd_delay: got %0d cycles, required %0d", w, VbatCyc);
    end
    pulse_frame_req();
    cs_seen = 1'b0;
    for (i = 0; i < 300; i++) begin @(negedge clk); if (!cs) cs_seen = 1'b1; end
    n_tests++;
    if (cs_seen || ready) begin
      n_fail++;
      $display("FAIL sd_halt: got cs_low=%0b ready=%0b, required 0 0", cs_seen, ready);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    #77;
    test_power_up();
    test_frame();
    test_pending();
    test_reset_mid_frame();
`ifdef OLED_SHUTDOWN_EN
    test_shutdown();
`endif
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d bytes outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
